// File: rtl/result_collector_pkg.sv
// Shared configuration for the result collector: default tile geometry and bank states.
// Optional ReLU stage is enabled by defining RESULT_COLLECTOR_RELU_EN.
package result_collector_pkg;

    localparam int CFG_S2P_SIZE    = 4;
    localparam int CFG_RESULT_SIZE = 32;
    localparam int CFG_OUT_WIDTH   = 8;

    localparam logic [1:0] BANK_EMPTY   = 2'd0;
    localparam logic [1:0] BANK_FILLING = 2'd1;
    localparam logic [1:0] BANK_FULL    = 2'd2;

endpackage : result_collector_pkg

// File: rtl/result_collector_requant_lane.sv
// One requantization lane: round half up, arithmetic shift, saturate.
// With RESULT_COLLECTOR_RELU_EN defined, negative results are clamped to zero.
module requant_lane
    import result_collector_pkg::*;
#(
    parameter int RESULT_SIZE = CFG_RESULT_SIZE,
    parameter int OUT_WIDTH   = CFG_OUT_WIDTH
) (
    input  logic [RESULT_SIZE-1:0] result,
    input  logic [4:0]             shift_amt,
    output logic [OUT_WIDTH-1:0]   element
);

    // One guard bit keeps the rounding add from overflowing.
    localparam int W = RESULT_SIZE + 1;
    localparam logic signed [W-1:0] SAT_MAX =
        $signed({{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [W-1:0] SAT_MIN =
        $signed({{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

    logic signed [W-1:0]   ext_s;
    logic signed [W-1:0]   bias_s;
    logic signed [W-1:0]   sum_s;
    logic signed [W-1:0]   shifted_s;
    logic [OUT_WIDTH-1:0]  sat_s;

    // Round, shift and saturate a single result.
    always_comb begin
        ext_s = $signed({result[RESULT_SIZE-1], result});
        if (shift_amt == 5'd0) begin
            bias_s = {W{1'b0}};
        end else begin
            bias_s = $signed({{(W-1){1'b0}}, 1'b1} << (shift_amt - 5'd1));
        end
        sum_s     = ext_s + bias_s;
        shifted_s = sum_s >>> shift_amt;
        if (shifted_s > SAT_MAX) begin
            sat_s = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (shifted_s < SAT_MIN) begin
            sat_s = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            sat_s = shifted_s[OUT_WIDTH-1:0];
        end
    end

`ifdef RESULT_COLLECTOR_RELU_EN
    // Clamp negative saturated values to zero.
    always_comb begin
        if (sat_s[OUT_WIDTH-1]) begin
            element = {OUT_WIDTH{1'b0}};
        end else begin
            element = sat_s;
        end
    end
`else
    assign element = sat_s;
`endif

endmodule : requant_lane

// File: rtl/result_collector.sv
// Collects requantized result rows into ping-pong tile banks and hands out whole tiles.
// Build option: RESULT_COLLECTOR_RELU_EN adds ReLU in every requant lane.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int S2P_SIZE    = CFG_S2P_SIZE,
    parameter int RESULT_SIZE = CFG_RESULT_SIZE,
    parameter int OUT_WIDTH   = CFG_OUT_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [S2P_SIZE*RESULT_SIZE-1:0]        row_product,
    input  logic                                   row_valid,
    input  logic                                   row_last,
    input  logic [4:0]                             shift_amt,
    output logic [S2P_SIZE*S2P_SIZE*OUT_WIDTH-1:0] tile_data,
    output logic                                   tile_valid,
    input  logic                                   tile_ready,
    output logic                                   err_overflow,
    output logic                                   err_misalign,
    input  logic                                   clear_err
);

    localparam int ROW_W  = S2P_SIZE * OUT_WIDTH;
    localparam int TILE_W = S2P_SIZE * ROW_W;
    localparam int CNT_W  = (S2P_SIZE > 1) ? $clog2(S2P_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(S2P_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ROW_W-1:0]             lane_row_s;
    logic                         s1_valid_r;
    logic                         s1_last_r;
    logic [ROW_W-1:0]             s1_row_r;

    logic [1:0][1:0]              bank_state_r;
    logic [1:0][1:0]              bank_state_s;
    logic [1:0][TILE_W-1:0]       bank_data_r;
    logic [1:0][TILE_W-1:0]       bank_data_s;
    logic                         wr_bank_r;
    logic                         wr_bank_s;
    logic                         rd_bank_r;
    logic                         rd_bank_s;
    logic [CNT_W-1:0]             row_cnt_r;
    logic [CNT_W-1:0]             row_cnt_s;
    int                           row_off_s;
    logic                         handshake_s;
    logic                         ovf_set_s;
    logic                         mis_set_s;

    logic                         tile_valid_r;
    logic [TILE_W-1:0]            tile_data_r;
    logic                         err_ovf_r;
    logic                         err_mis_r;

    // Column 0 sits at the MSBs on both the input row and the packed output row.
    for (genvar g = 0; g < S2P_SIZE; g++) begin : g_lane
        requant_lane #(
            .RESULT_SIZE (RESULT_SIZE),
            .OUT_WIDTH   (OUT_WIDTH)
        ) u_lane (
            .result    (row_product[(S2P_SIZE-1-g)*RESULT_SIZE +: RESULT_SIZE]),
            .shift_amt (shift_amt),
            .element   (lane_row_s[(S2P_SIZE-1-g)*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // Stage 1: capture the requantized row with its qualifiers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_row_r   <= {ROW_W{1'b0}};
        end else begin
            s1_valid_r <= row_valid;
            s1_last_r  <= row_valid & row_last;
            if (row_valid) begin
                s1_row_r <= lane_row_s;
            end
        end
    end

    // Stage 2 next-state: bank write, fill/drop/misalign decisions and read handshake.
    always_comb begin
        bank_state_s = bank_state_r;
        bank_data_s  = bank_data_r;
        wr_bank_s    = wr_bank_r;
        rd_bank_s    = rd_bank_r;
        row_cnt_s    = row_cnt_r;
        ovf_set_s    = 1'b0;
        mis_set_s    = 1'b0;
        row_off_s    = (S2P_SIZE - 1 - int'(row_cnt_r)) * ROW_W;
        handshake_s  = tile_valid_r & tile_ready;

        if (handshake_s) begin
            bank_state_s[rd_bank_r] = BANK_EMPTY;
            rd_bank_s               = ~rd_bank_r;
        end else begin
            rd_bank_s = rd_bank_r;
        end

        // The handshaken bank is FULL, so it is never the bank written below.
        if (s1_valid_r) begin
            if (bank_state_r[wr_bank_r] == BANK_FULL) begin
                ovf_set_s = 1'b1;
            end else if (row_cnt_r == LAST_ROW) begin
                bank_data_s[wr_bank_r][row_off_s +: ROW_W] = s1_row_r;
                bank_state_s[wr_bank_r] = BANK_FULL;
                wr_bank_s               = ~wr_bank_r;
                row_cnt_s               = {CNT_W{1'b0}};
            end else if (s1_last_r) begin
                bank_state_s[wr_bank_r] = BANK_EMPTY;
                row_cnt_s               = {CNT_W{1'b0}};
                mis_set_s               = 1'b1;
            end else begin
                bank_data_s[wr_bank_r][row_off_s +: ROW_W] = s1_row_r;
                bank_state_s[wr_bank_r] = BANK_FILLING;
                row_cnt_s               = row_cnt_r + CNT_ONE;
            end
        end else begin
            row_cnt_s = row_cnt_r;
        end
    end

    // Bank state, pointers and registered tile outputs.
    always_ff @(posedge clk) begin
        if (rstn) begin
            bank_state_r <= {2{BANK_EMPTY}};
            bank_data_r  <= {(2*TILE_W){1'b0}};
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= 1'b0;
            row_cnt_r    <= {CNT_W{1'b0}};
            tile_valid_r <= 1'b0;
            tile_data_r  <= {TILE_W{1'b0}};
        end else begin
            bank_state_r <= bank_state_s;
            bank_data_r  <= bank_data_s;
            wr_bank_r    <= wr_bank_s;
            rd_bank_r    <= rd_bank_s;
            row_cnt_r    <= row_cnt_s;
            tile_valid_r <= (bank_state_s[rd_bank_s] == BANK_FULL);
            if (bank_state_s[rd_bank_s] == BANK_FULL) begin
                tile_data_r <= bank_data_s[rd_bank_s];
            end
        end
    end

    // Sticky error flags; a same-cycle set wins over clear_err.
    always_ff @(posedge clk) begin
        if (rstn) begin
            err_ovf_r <= 1'b0;
            err_mis_r <= 1'b0;
        end else begin
            err_ovf_r <= ovf_set_s | (err_ovf_r & ~clear_err);
            err_mis_r <= mis_set_s | (err_mis_r & ~clear_err);
        end
    end

    assign tile_valid   = tile_valid_r;
    assign tile_data    = tile_data_r;
    assign err_overflow = err_ovf_r;
    assign err_misalign = err_mis_r;

endmodule : result_collector

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter S2P_SIZE, default 4: tile edge N; rows per tile and results per row.
REQ-002 Parameter RESULT_SIZE, default 32: signed width of each incoming dot-product result.
REQ-003 Parameter OUT_WIDTH, default 8: signed width of each requantized output element.
REQ-004 Port clk, in, 1: single clock; all logic on its rising edge.
REQ-005 Port rstn, in, 1: reset, synchronous and active-high despite the name.
REQ-006 Port row_product, in, S2P_SIZE*RESULT_SIZE: one result row; column 0 at the MSBs.
REQ-007 Port row_valid, in, 1: one-cycle pulse qualifying row_product; driven by the upstream per-row done.
REQ-008 Port row_last, in, 1: marks the final row of a tile; meaningful only with row_valid.
REQ-009 Port shift_amt, in, 5: requantization right-shift amount; changed only while the block is idle.
REQ-010 Port tile_data, out, S2P_SIZE*S2P_SIZE*OUT_WIDTH: full tile; row 0/column 0 at the MSBs.
REQ-011 Port tile_valid, out, 1: tile_data holds a complete tile.
REQ-012 Port tile_ready, in, 1: consumer accepts; transfer occurs when valid and ready are both high.
REQ-013 Port err_overflow, out, 1: sticky flag; a row was dropped because no bank was free.
REQ-014 Port err_misalign, out, 1: sticky flag; row_last arrived with a wrong row count.
REQ-015 Port clear_err, in, 1: clears both sticky flags on the next edge.

Function
REQ-016 The block has no backpressure to upstream: row_valid is never stalled and every row is either stored or dropped.
REQ-017 Each result: if s>0, add 2^(s-1) (round half up); arithmetic shift right by s; saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-018 Stage 1: on the edge that samples row_valid, the requantized row, valid and last are registered.
REQ-019 Stage 2: on the next edge, the row is written to row slot row_cnt of the current write bank, and row_cnt increments.
REQ-020 Two tile banks (ping-pong). Each bank is in state EMPTY, FILLING or FULL.
REQ-021 EMPTY->FILLING on the first row write; FILLING->FULL on the write of row N-1 (row_cnt wraps to 0 and the write bank toggles); FULL->EMPTY on handshake.
REQ-022 tile_valid is high whenever the read bank is FULL. It is first visible in the cycle after the stage-2 edge, giving 2 cycles of latency from the last row_valid.
REQ-023 tile_data and tile_valid hold stable until the handshake; the read bank toggles on the handshake.
REQ-024 A handshake and a bank-fill on the same edge are both honoured; the next tile_valid comes from the other bank without a bubble if that bank is FULL.
REQ-025 If the write bank is FULL at stage 2, the row is dropped, err_overflow is set, and row_cnt is unchanged.
REQ-026 A row with row_last=1 written at row_cnt!=N-1 sets err_misalign. The partial bank returns to EMPTY, row_cnt returns to 0, and no tile is emitted.
REQ-027 A row with row_last=0 written at row_cnt=N-1 completes the tile normally.
REQ-028 clear_err has priority below a same-cycle error set: the flag stays set.

Reset
REQ-029 When rstn=1 at an edge: both banks go EMPTY, row_cnt=0, pipeline valid=0, tile_valid=0, tile_data=0, err_overflow=0, err_misalign=0.
REQ-030 A reset mid-tile or mid-handshake discards all buffered data with no partial output.

Configuration
REQ-031 Macro RESULT_COLLECTOR_RELU_EN defined: after saturation, negative elements are forced to 0.
REQ-032 Macro RESULT_COLLECTOR_RELU_EN undefined: signed saturated values pass unchanged; there is no ReLU logic.

Structure
REQ-033 S2P_SIZE, RESULT_SIZE, OUT_WIDTH defaults and the bank-state encoding (EMPTY=0, FILLING=1, FULL=2) live in the shared config include.
REQ-034 Sub-module requant_lane handles one element's round, shift, saturate and optional ReLU; S2P_SIZE instances are generated.

Verification
REQ-035 N=4, s=4, rows of all results = 0x00000028 (40), tile_ready=1: tile_valid is seen 2 cycles after the 4th row_valid, every element = 3 (40+8=48, 48>>4=3).
REQ-036 Saturation: s=0, results +1000 / -1000 -> elements 127 / -128. With RELU_EN: 127 / 0.
REQ-037 Backpressure: tile_ready=0, send 3 tiles back-to-back -> tiles 1 and 2 are held, all of tile 3 is dropped, err_overflow=1. Raising ready then yields tiles 1 and 2 in order.
REQ-038 Misalign: row_last on the 2nd row -> err_misalign=1 and no tile. The next 4 rows form a correct tile.
REQ-039 Same-edge handshake and bank fill: continuous 1 row/cycle with ready toggling -> no lost tiles and the tile order is preserved.
REQ-040 Reset asserted after 2 rows -> outputs zero. The next 4 rows produce exactly one tile with no stale data.
